seq_calculator: RTL and testbench
=================================

Name: seq_calculator

Overview:
- Clocked, parametrised successor to the board-level 4-bit adder/display block.
- Takes two WIDTH-bit operands and a 2-bit opcode from the switches. A button press starts an operation: add, subtract, shift-add multiply, or accumulate.
- Holds the 2*WIDTH-bit result in a register and drives it onto active-low seven-segment displays.
- Sits directly under the board top level: switches and keys in, HEX segments and LED flags out.

Parameters:
- WIDTH, 4, operand width in bits. Must be even and >= 4.
- NDIG, WIDTH/2, number of result hex digits (2*WIDTH/4). Derived; not overridden.

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge.
- RESET_N  input  1  reset, asynchronous assert, active-low.
- SW  input  2*WIDTH+2  A=SW[WIDTH-1:0], B=SW[2*WIDTH-1:WIDTH], OP=SW[2*WIDTH+1:2*WIDTH].
- KEY_START_N  input  1  start push-button, active-low, asynchronous to CLOCK_50.
- RESULT  output  2*WIDTH  registered result.
- CARRY  output  1  carry/borrow/overflow flag of the last completed operation.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when RESULT/CARRY update.
- HEX  output  NDIG x 7  digit i shows RESULT[4i+3:4i]. Active-low segments, bit0=a ... bit6=g, glyphs 0-9, A-F.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - RESULT=0, CARRY=0, BUSY=0, DONE=0.
  - Accumulator=0, FSM=IDLE, synchroniser flops=1.
  - HEX shows all "0" (7'b1000000).
- Reset mid-operation aborts the operation: no DONE, and RESULT reads 0.
- Start detection:
  - KEY_START_N passes through a 2-flop synchroniser.
  - A press is the sync'd value going 1->0, which gives a one-cycle internal start pulse.
  - Holding the key produces exactly one start. A new press requires release (sync'd 1) first.
  - Call edge N the clock edge at which the FSM sees the start pulse. That is the second edge after KEY_START_N is first sampled low.
- FSM states: IDLE, CALC, DONE.
  - IDLE: BUSY=0. On start at edge N, latch A, B and OP into internal registers, load iteration count, go to CALC.
  - CALC: BUSY=1.
    - ADD/SUB/ACC take 1 iteration.
    - MUL takes WIDTH iterations (one partial product per cycle, LSB of multiplier first).
    - At the edge completing the last iteration, write RESULT/CARRY and go to DONE.
  - DONE: DONE=1, BUSY=0 for exactly one cycle, then IDLE.
- Latency from edge N to RESULT update:
  - ADD/SUB/ACC: RESULT valid after edge N+1, DONE high in the cycle after N+1.
  - MUL: RESULT valid after edge N+WIDTH, DONE high in the cycle after N+WIDTH.
- Starts while in CALC or DONE are ignored, not queued.
- SW changes after edge N do not affect the running operation. RESULT is held until the next completion.
- Arithmetic:
  - OP=00 ADD: RESULT = zero-extended A+B (WIDTH+1 bits). CARRY = bit WIDTH of the sum.
  - OP=01 SUB: RESULT[WIDTH-1:0] = (A-B) mod 2^WIDTH, upper bits 0. CARRY = borrow (1 iff A<B).
  - OP=10 MUL: RESULT = A*B, full 2*WIDTH bits, unsigned. CARRY = 0.
  - OP=11 ACC: accumulator = (accumulator + zero-extended A) mod 2^(2*WIDTH). RESULT = new accumulator. CARRY = carry out of bit 2*WIDTH-1 (wrap). B is ignored.
- The accumulator is changed only by OP=11 and by reset.
- HEX outputs are combinational decodes of RESULT.

Test Plan (WIDTH=4):
- Reset: assert RESET_N low mid-MUL -> RESULT=0x00, CARRY=0, BUSY=0, no DONE, HEX0=HEX1=7'b1000000.
- ADD A=9 B=8: press -> at N+1 RESULT=0x11, CARRY=1, DONE exactly one cycle, HEX1/HEX0 show "1","1". A=3 B=4 -> RESULT=0x07, CARRY=0.
- SUB A=3 B=5: press -> RESULT=0x0E, CARRY=1. A=7 B=2 -> RESULT=0x05, CARRY=0.
- MUL A=F B=F: press -> BUSY high for 4 cycles, RESULT=0xE1 after edge N+4, CARRY=0. Toggle SW during BUSY -> result unchanged.
- ACC: 18 presses with A=F from reset -> RESULT 0x0F, 0x1E, ... 0xFF at the 17th. The 18th press wraps to 0x0E, CARRY=1.
- Handshake: hold key 100 cycles -> exactly one DONE. Press again while BUSY (MUL) -> ignored, one DONE total. Glitch-free release/repress -> second operation runs.

Source files
------------

// File: rtl/seq_calculator.sv
// Sequential calculator: add, subtract, shift-add multiply and accumulate on switch operands,
// started by a debounced-free synchronised key press, result shown on active-low hex displays.
module seq_calculator #(
    parameter int WIDTH = 4,
    localparam int NDIG = WIDTH / 2
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [2*WIDTH+1:0]   SW,
    input  logic                 KEY_START_N,
    output logic [2*WIDTH-1:0]   RESULT,
    output logic                 CARRY,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [NDIG-1:0][6:0] HEX
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpAcc = 2'b11;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            r_state;
    state_e            w_state_d;

    logic              r_meta;
    logic              r_sync;
    logic              r_sync_prev;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_op;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [RW-1:0]     r_prod;
    logic [RW-1:0]     r_acc;
    logic [RW-1:0]     r_result;
    logic              r_carry;

    logic              w_start;
    logic              w_last;
    logic [RW-1:0]     w_pp;
    logic [RW-1:0]     w_prod_next;
    logic [WIDTH:0]    w_add;
    logic [WIDTH:0]    w_sub;
    logic [RW:0]       w_acc_sum;
    logic [RW-1:0]     w_res;
    logic              w_cy;

    // Falling edge of the synchronised key is the one-cycle start request.
    assign w_start     = r_sync_prev & ~r_sync;
    assign w_last      = (r_cnt == '0);
    assign w_pp        = r_mplier[0] ? r_mcand : '0;
    assign w_prod_next = r_prod + w_pp;
    assign w_add       = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub       = {1'b0, r_a} - {1'b0, r_b};
    assign w_acc_sum   = {1'b0, r_acc} + (RW + 1)'(r_a);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_d = StCalc;
            StCalc:  if (w_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        unique case (r_op)
            OpAdd: begin
                w_res = RW'(w_add);
                w_cy  = w_add[WIDTH];
            end
            OpSub: begin
                w_res = RW'(w_sub[WIDTH-1:0]);
                w_cy  = w_sub[WIDTH];
            end
            OpMul: begin
                w_res = w_prod_next;
                w_cy  = 1'b0;
            end
            OpAcc: begin
                w_res = w_acc_sum[RW-1:0];
                w_cy  = w_acc_sum[RW];
            end
            default: begin
                w_res = '0;
                w_cy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_meta      <= 1'b1;
            r_sync      <= 1'b1;
            r_sync_prev <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
        end else begin
            r_meta      <= KEY_START_N;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
            if (r_state == StIdle && w_start) begin
                r_a      <= SW[WIDTH-1:0];
                r_b      <= SW[2*WIDTH-1:WIDTH];
                r_op     <= SW[2*WIDTH+1:2*WIDTH];
                r_cnt    <= (SW[2*WIDTH+1:2*WIDTH] == OpMul) ? CW'(WIDTH - 1) : '0;
                r_mcand  <= RW'(SW[WIDTH-1:0]);
                r_mplier <= SW[2*WIDTH-1:WIDTH];
                r_prod   <= '0;
            end else if (r_state == StCalc) begin
                if (w_last) begin
                    r_result <= w_res;
                    r_carry  <= w_cy;
                    if (r_op == OpAcc) r_acc <= w_acc_sum[RW-1:0];
                end else begin
                    // One partial product per cycle, multiplier LSB first.
                    r_cnt    <= r_cnt - CW'(1);
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                end
            end
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            HEX[i] = f_seg(r_result[4*i +: 4]);
        end
    end

    assign RESULT = r_result;
    assign CARRY  = r_carry;
    assign BUSY   = (r_state == StCalc);
    assign DONE   = (r_state == StDone);

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (WIDTH=4): per-cycle compare against a behavioural
// model plus directed literal expectations.
module tb_seq_calculator;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic            CLOCK_50;
    logic            RESET_N;
    logic [RW+1:0]   SW;
    logic            KEY_START_N;
    logic [RW-1:0]   RESULT;
    logic            CARRY;
    logic            BUSY;
    logic            DONE;
    logic [1:0][6:0] HEX;

    seq_calculator #(.WIDTH(W)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .SW          (SW),
        .KEY_START_N (KEY_START_N),
        .RESULT      (RESULT),
        .CARRY       (CARRY),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .HEX         (HEX)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 0;

    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
        glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
        glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
        glyph[15] = 7'b0001110;
    end

    // Behavioural model: key sample history, remaining busy cycles, pending result.
    logic [2:0] m_hist    = 3'b111;
    int         m_left    = 0;
    bit         m_done    = 0;
    int         m_res     = 0;
    bit         m_cy      = 0;
    int         m_acc     = 0;
    int         p_res     = 0;
    bit         p_cy      = 0;
    bit         p_is_acc  = 0;

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            m_hist = 3'b111; m_left = 0; m_done = 0; m_res = 0; m_cy = 0; m_acc = 0;
        end else begin
            int a, b, op;
            bit start, nd;
            a     = int'(SW[W-1:0]);
            b     = int'(SW[2*W-1:W]);
            op    = int'(SW[2*W+1:2*W]);
            start = (m_hist[1] == 1'b0) && (m_hist[2] == 1'b1);
            nd    = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = p_res; m_cy = p_cy; nd = 1;
                    if (p_is_acc) m_acc = p_res;
                end
            end else if (!m_done && start) begin
                p_is_acc = (op == 3);
                case (op)
                    0: begin p_res = a + b; p_cy = (a + b) >= (1 << W); end
                    1: begin p_res = (a >= b) ? a - b : a - b + (1 << W); p_cy = a < b; end
                    2: begin p_res = a * b; p_cy = 0; end
                    default: begin
                        p_res = (m_acc + a) % (1 << RW); p_cy = (m_acc + a) >= (1 << RW);
                    end
                endcase
                m_left = (op == 2) ? W : 1;
            end
            m_done = nd;
            m_hist = {m_hist[1:0], KEY_START_N};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("result", 32'(RESULT), 32'(m_res));
            chk("carry", 32'(CARRY), 32'(m_cy));
            chk("busy", 32'(BUSY), 32'(m_left > 0));
            chk("done", 32'(DONE), 32'(m_done));
            chk("hex0", 32'(HEX[0]), 32'(glyph[m_res % 16]));
            chk("hex1", 32'(HEX[1]), 32'(glyph[(m_res / 16) % 16]));
        end
    end

    always @(negedge CLOCK_50) if (DONE === 1'b1) n_done++;

    task automatic wait_done(input string tag);
        int k = 0;
        do begin @(negedge CLOCK_50); k++; end while (DONE !== 1'b1 && k < 40);
        n_cmp++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: DONE=%b want 1", tag, DONE);
        end
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        do begin @(negedge CLOCK_50); k++; end while (BUSY !== 1'b1 && k < 40);
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_timeout: BUSY=%b want 1", tag, BUSY);
        end
    endtask

    task automatic release_key();
        KEY_START_N = 1'b1;
        @(negedge CLOCK_50);
        chk("done_one_cycle", 32'(DONE), 32'd0);
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input string tag, input logic [7:0] exp_res, input logic exp_cy);
        @(negedge CLOCK_50);
        SW = {op, b, a};
        KEY_START_N = 1'b0;
        wait_done(tag);
        chk({tag, "_res"}, 32'(RESULT), 32'(exp_res));
        chk({tag, "_cy"}, 32'(CARRY), 32'(exp_cy));
        chk({tag, "_model"}, 32'(m_res), 32'(exp_res));
    endtask

    initial begin
        int d0;
        RESET_N = 1'b0;
        KEY_START_N = 1'b1;
        SW = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_result", 32'(RESULT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_hex0", 32'(HEX[0]), 32'h40);
        chk_en = 1;
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        run_op(2'b00, 4'h9, 4'h8, "add98", 8'h11, 1'b1);
        chk("add98_hex0", 32'(HEX[0]), 32'b1111001);
        chk("add98_hex1", 32'(HEX[1]), 32'b1111001);
        release_key();
        run_op(2'b00, 4'h3, 4'h4, "add34", 8'h07, 1'b0); release_key();
        run_op(2'b00, 4'hF, 4'hF, "addff", 8'h1E, 1'b1); release_key();
        run_op(2'b01, 4'h3, 4'h5, "sub35", 8'h0E, 1'b1); release_key();
        run_op(2'b01, 4'h7, 4'h2, "sub72", 8'h05, 1'b0); release_key();
        run_op(2'b01, 4'h0, 4'hF, "sub0f", 8'h01, 1'b1); release_key();
        run_op(2'b10, 4'hA, 4'hB, "mulab", 8'h6E, 1'b0); release_key();
        run_op(2'b10, 4'h0, 4'h9, "mul09", 8'h00, 1'b0); release_key();

        // MUL F*F with switches scrambled while busy; BUSY must last exactly WIDTH cycles.
        @(negedge CLOCK_50);
        SW = {2'b10, 4'hF, 4'hF};
        KEY_START_N = 1'b0;
        wait_busy("mulff");
        SW = {2'b00, 4'h1, 4'h2};
        repeat (3) @(negedge CLOCK_50);
        chk("mulff_busy4", 32'(BUSY), 32'd1);
        @(negedge CLOCK_50);
        chk("mulff_done", 32'(DONE), 32'd1);
        chk("mulff_res", 32'(RESULT), 32'hE1);
        chk("mulff_cy", 32'(CARRY), 32'h0);
        release_key();

        // Holding the key for 100 cycles yields exactly one operation.
        d0 = n_done;
        @(negedge CLOCK_50);
        SW = {2'b00, 4'h2, 4'h1};
        KEY_START_N = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        KEY_START_N = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        chk("hold_done_count", 32'(n_done - d0), 32'd1);
        chk("hold_res", 32'(RESULT), 32'h03);

        // A second press landing while MUL is busy is dropped.
        d0 = n_done;
        @(negedge CLOCK_50);
        SW = {2'b10, 4'h5, 4'h3};
        KEY_START_N = 1'b0;
        wait_busy("busyign");
        KEY_START_N = 1'b1;
        @(negedge CLOCK_50);
        KEY_START_N = 1'b0;
        repeat (12) @(negedge CLOCK_50);
        KEY_START_N = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        chk("busyign_done_count", 32'(n_done - d0), 32'd1);
        chk("busyign_res", 32'(RESULT), 32'h0F);

        // Reset in the middle of a MUL aborts it.
        d0 = n_done;
        @(negedge CLOCK_50);
        SW = {2'b10, 4'h7, 4'h7};
        KEY_START_N = 1'b0;
        wait_busy("rstmul");
        #2 RESET_N = 1'b0;
        #1;
        chk("rstmul_result", 32'(RESULT), 32'h0);
        chk("rstmul_carry", 32'(CARRY), 32'h0);
        chk("rstmul_busy", 32'(BUSY), 32'h0);
        chk("rstmul_done", 32'(DONE), 32'h0);
        chk("rstmul_hex0", 32'(HEX[0]), 32'b1000000);
        chk("rstmul_hex1", 32'(HEX[1]), 32'b1000000);
        KEY_START_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        #2 RESET_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        chk("rstmul_no_done", 32'(n_done - d0), 32'd0);
        chk("rstmul_res_after", 32'(RESULT), 32'h0);

        // Accumulate A=F eighteen times from reset; the last one wraps.
        for (int i = 1; i <= 18; i++) begin
            run_op(2'b11, 4'hF, 4'h6, "acc", 8'((i * 15) % 256), (i == 18));
            release_key();
        end

        repeat (3) @(negedge CLOCK_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
